// File: rtl/fcl_fp_pkg.sv
// fcl_fp_pkg: shared sequencer state encoding and datapath shift width for the FC layer
package fcl_fp_pkg;

    localparam int SHIFT_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_PRIME,
        S_RUN,
        S_DRAIN,
        S_EMIT,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/fcl_fp_seq.sv
// fcl_fp_seq: drives fcl_fp through one FC layer, PARALLEL_NUM outputs per group; FCL_SEQ_PERF_EN adds a weight-stall counter
module fcl_fp_seq
    import fcl_fp_pkg::*;
#(
    parameter int DATAWIDTH    = 8,
    parameter int PARALLEL_NUM = 4,
    parameter int MAX_DIM      = 1024,
    parameter int DP_LAT       = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [$clog2(MAX_DIM+1)-1:0]      n_in,
    input  logic [$clog2(MAX_DIM+1)-1:0]      n_out,
    input  logic [SHIFT_W-1:0]                shift_cfg,
    output logic                              done,
    output logic [$clog2(MAX_DIM)-1:0]        act_rd_addr,
    input  logic [DATAWIDTH-1:0]              act_rd_data,
    input  logic                              w_valid,
    output logic                              w_ready,
    input  logic [PARALLEL_NUM*DATAWIDTH-1:0] w_data,
    output logic                              dp_en,
    output logic                              dp_clr,
    output logic [DATAWIDTH-1:0]              dp_input,
    output logic [PARALLEL_NUM*DATAWIDTH-1:0] dp_w,
    output logic [SHIFT_W-1:0]                dp_shift,
    input  logic [PARALLEL_NUM*DATAWIDTH-1:0] dp_out,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [PARALLEL_NUM*DATAWIDTH-1:0] res_data,
    output logic [31:0]                       perf_stall_cnt
);

    localparam int NW = $clog2(MAX_DIM + 1);
    localparam int AW = $clog2(MAX_DIM);
    localparam int CW = $clog2(DP_LAT + 1);

    seq_state_t    state;
    logic [NW-1:0] n_in_q, n_out_q, in_cnt;
    logic [NW:0]   out_base;
    logic [CW-1:0] lat_cnt;
    logic          cfg_ok, accept, hs, last_beat, last_grp;

    assign cfg_ok    = n_in != '0 && n_in <= NW'(MAX_DIM) && n_out != '0 && n_out <= NW'(MAX_DIM)
                       && n_out % NW'(PARALLEL_NUM) == '0;
    assign accept    = state == S_IDLE && start && cfg_ok;
    assign hs        = state == S_RUN && w_valid;
    assign last_beat = in_cnt == n_in_q - 1'b1;
    assign last_grp  = out_base + (NW+1)'(PARALLEL_NUM) == {1'b0, n_out_q};

    // The activation RAM answers one cycle late, so the address always points at the next needed beat
    assign act_rd_addr = AW'(in_cnt + NW'(hs));
    assign w_ready     = state == S_RUN;
    assign dp_en       = hs;
    assign dp_input    = hs ? act_rd_data : '0;
    assign dp_w        = hs ? w_data : '0;
    assign res_valid   = state == S_EMIT;
    assign done        = state == S_DONE;

    // Layer sequencing: clear, prime the RAM read, stream n_in beats, wait out datapath latency, hand off result
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            dp_clr   <= 1'b1;
            n_in_q   <= '0;
            n_out_q  <= '0;
            in_cnt   <= '0;
            out_base <= '0;
            lat_cnt  <= '0;
            res_data <= '0;
            dp_shift <= '0;
        end else begin
            dp_clr <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    state    <= S_CLR;
                    dp_clr   <= 1'b1;
                    n_in_q   <= n_in;
                    n_out_q  <= n_out;
                    dp_shift <= shift_cfg;
                    out_base <= '0;
                end
                S_CLR:   state <= S_PRIME;
                S_PRIME: state <= S_RUN;
                S_RUN: if (hs) begin
                    in_cnt <= last_beat ? '0 : in_cnt + 1'b1;
                    if (last_beat) begin
                        state   <= S_DRAIN;
                        lat_cnt <= CW'(1);
                    end
                end
                S_DRAIN: if (lat_cnt == CW'(DP_LAT)) begin
                    res_data <= dp_out;
                    state    <= S_EMIT;
                end else begin
                    lat_cnt <= lat_cnt + 1'b1;
                end
                S_EMIT: if (res_ready) begin
                    if (last_grp) begin
                        state <= S_DONE;
                    end else begin
                        out_base <= out_base + (NW+1)'(PARALLEL_NUM);
                        state    <= S_CLR;
                        dp_clr   <= 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FCL_SEQ_PERF_EN
    // Saturating count of RUN cycles lost waiting for weights, restarted with each accepted layer
    always_ff @(posedge clk) begin
        if (rst || accept)
            perf_stall_cnt <= '0;
        else if (state == S_RUN && !w_valid && perf_stall_cnt != '1)
            perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fcl_fp_seq.sv
// tb_fcl_fp_seq: directed and randomized layers against a dot-product reference of each output group
module tb_fcl_fp_seq;
    import fcl_fp_pkg::*;

    localparam int DW  = 8;
    localparam int P   = 4;
    localparam int MD  = 1024;
    localparam int LAT = 1;

    logic                 clk = 0, rst = 1, start = 0, w_valid = 0, res_ready = 0;
    logic                 done, w_ready, dp_en, dp_clr, res_valid;
    logic [10:0]          n_in = 0, n_out = 0;
    logic [SHIFT_W-1:0]   shift_cfg = 0, dp_shift;
    logic [9:0]           act_rd_addr;
    logic [DW-1:0]        act_rd_data = 0, dp_input;
    logic [P*DW-1:0]      w_data = 0, dp_w, dp_out, res_data;
    logic [31:0]          perf_stall_cnt;

    logic [DW-1:0]        act_mem [MD];
    logic [P*DW-1:0]      wmem [4][16];
    logic [31:0]          acc [P];
    logic [P*DW-1:0]      got [$];

    int   n_tests = 0, n_fail = 0;
    logic stats_clr = 0, stall_mode = 0, rmode = 0;
    int   w_prob = 100, r_prob = 100;
    int   beat_tb = 0, grp_tb = 0, clr_cnt = 0, en_cnt = 0, done_cnt = 0, since_last = 0;
    int   stalls_done = 0, rhold = 0;
    int   bad_beat = 0, bad_addr = 0, bad_wr = 0, bad_hold = 0, bad_lat = 0, bad_done = 0;
    logic hold_pending = 0, rv_d = 0, acc_d = 0, wstall, rstall;
    logic [P*DW-1:0] held = 0;

    fcl_fp_seq #(.DATAWIDTH(DW), .PARALLEL_NUM(P), .MAX_DIM(MD), .DP_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .n_in(n_in), .n_out(n_out), .shift_cfg(shift_cfg),
        .done(done), .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .dp_en(dp_en), .dp_clr(dp_clr), .dp_input(dp_input), .dp_w(dp_w), .dp_shift(dp_shift),
        .dp_out(dp_out), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    // Activation RAM with one-cycle read latency, and a one-cycle-latency MAC datapath
    always @(posedge clk) begin
        act_rd_data <= act_mem[act_rd_addr];
        for (int l = 0; l < P; l++)
            acc[l] <= dp_clr ? 32'd0 : dp_en ? acc[l] + 32'(dp_input) * 32'(dp_w[l*DW +: DW]) : acc[l];
    end

    always_comb begin
        dp_out = '0;
        for (int l = 0; l < P; l++) dp_out[l*DW +: DW] = DW'(acc[l] >> dp_shift);
    end

    // Drive weight/result handshakes at negedge, then observe the settled cycle 1 ns later
    always @(negedge clk) begin
        wstall = stall_mode && w_ready && beat_tb == 1 && stalls_done < 2;
        rstall = rmode && res_valid && grp_tb == 0 && rhold < 5;
        if (wstall) stalls_done++;
        if (rstall) rhold++;
        w_valid   = stall_mode ? !wstall : ($urandom_range(0, 99) < w_prob);
        w_data    = wmem[grp_tb % 4][beat_tb % 16];
        res_ready = rstall ? 1'b0 : ($urandom_range(0, 99) < r_prob);
        #1;
        if (stats_clr) begin
            beat_tb = 0; grp_tb = 0; clr_cnt = 0; en_cnt = 0; done_cnt = 0; since_last = 0;
            stalls_done = 0; rhold = 0; hold_pending = 0; rv_d = 0; acc_d = 0;
            bad_beat = 0; bad_addr = 0; bad_wr = 0; bad_hold = 0; bad_lat = 0; bad_done = 0;
            got.delete();
        end else begin
            if (dp_en !== (w_ready && w_valid)) bad_beat++;
            if (dp_en && (dp_input !== act_mem[beat_tb] || dp_w !== wmem[grp_tb % 4][beat_tb % 16])) bad_beat++;
            if (w_ready && !w_valid && act_rd_addr !== 10'(beat_tb)) bad_addr++;
            if (res_valid && w_ready) bad_wr++;
            if (hold_pending && (!res_valid || res_data !== held)) bad_hold++;
            hold_pending = res_valid && !res_ready;
            held = res_data;
            if (res_valid && !rv_d && since_last != LAT) bad_lat++;
            rv_d = res_valid;
            if (done && !acc_d) bad_done++;
            acc_d = res_valid && res_ready;
            if (res_valid && res_ready) begin
                got.push_back(res_data);
                grp_tb++;
            end
            if (dp_clr && !rst) clr_cnt++;
            if (dp_en) en_cnt++;
            since_last = (dp_en && beat_tb == int'(n_in) - 1) ? 0 : since_last + 1;
            if (dp_clr) stalls_done = 0;
            if (dp_clr || rst) beat_tb = 0;
            else if (dp_en) beat_tb++;
            if (done || rst) grp_tb = 0;
            if (done) done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [P*DW-1:0] expect_grp(input int g, input int ni, input int sh);
        logic [P*DW-1:0] r;
        logic [31:0] s;
        r = '0;
        for (int l = 0; l < P; l++) begin
            s = 0;
            for (int k = 0; k < ni; k++) s += 32'(act_mem[k]) * 32'(wmem[g][k][l*DW +: DW]);
            r[l*DW +: DW] = DW'(s >> sh);
        end
        return r;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_w_ready"}, w_ready, 0);
        chk({tag, "_dp_en"}, dp_en, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_dp_clr"}, dp_clr, 1);
        chk({tag, "_addr"}, act_rd_addr, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_dp_input"}, dp_input, 0);
        chk({tag, "_dp_w"}, dp_w, 0);
        chk({tag, "_dp_shift"}, dp_shift, 0);
        chk({tag, "_perf"}, perf_stall_cnt, 0);
    endtask

    task automatic start_layer(input int ni, input int no, input int sh);
        for (int k = 0; k < 16; k++) act_mem[k] = DW'($urandom);
        for (int g = 0; g < 4; g++)
            for (int k = 0; k < 16; k++) wmem[g][k] = $urandom;
        @(negedge clk);
        stats_clr = 1;
        @(negedge clk);
        stats_clr = 0;
        n_in      = 11'(ni);
        n_out     = 11'(no);
        shift_cfg = SHIFT_W'(sh);
        start     = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic finish_layer(input int ni, input int no, input int sh);
        int cyc = 0;
        while (done_cnt == 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);
        #2;
        chk("done_once", done_cnt, 1);
        chk("groups", got.size(), no / P);
        for (int g = 0; g < no / P; g++)
            chk($sformatf("res_g%0d", g), g < got.size() ? got[g] : 32'hdeadbeef, expect_grp(g, ni, sh));
        chk("beats", en_cnt, ni * (no / P));
        chk("clrs", clr_cnt, no / P);
        chk("beat_data", bad_beat, 0);
        chk("stall_addr", bad_addr, 0);
        chk("w_ready_in_emit", bad_wr, 0);
        chk("res_hold", bad_hold, 0);
        chk("res_latency", bad_lat, 0);
        chk("done_after_accept", bad_done, 0);
        chk("shift", dp_shift, sh);
    endtask

    task automatic run_layer(input int ni, input int no, input int sh);
        start_layer(ni, no, sh);
        finish_layer(ni, no, sh);
    endtask

    initial begin
        int ni, no, sh, cyc;
        for (int i = 0; i < MD; i++) act_mem[i] = DW'($urandom);
        for (int g = 0; g < 4; g++)
            for (int k = 0; k < 16; k++) wmem[g][k] = $urandom;
        repeat (3) @(negedge clk);
        #2;
        check_reset("por");
        rst = 0;

        run_layer(3, 4, 2);

        stall_mode = 1;
        run_layer(3, 4, 0);
`ifdef FCL_SEQ_PERF_EN
        chk("perf_stalls", perf_stall_cnt, 2);
`else
        chk("perf_stalls", perf_stall_cnt, 0);
`endif
        stall_mode = 0;

        rmode = 1;
        run_layer(5, 8, 1);
        rmode = 0;

        for (int t = 0; t < 6; t++) begin
            w_prob = int'($urandom_range(40, 100));
            r_prob = int'($urandom_range(30, 100));
            ni = int'($urandom_range(1, 16));
            no = 4 * int'($urandom_range(1, 4));
            sh = int'($urandom_range(0, 7));
            run_layer(ni, no, sh);
        end
        w_prob = 100;
        r_prob = 100;

        start_layer(3, 6, 0);
        start_layer(0, 4, 0);
        start_layer(3, 0, 0);
        repeat (10) @(negedge clk);
        #2;
        chk("bad_cfg_clr", clr_cnt, 0);
        chk("bad_cfg_done", done_cnt, 0);
        chk("bad_cfg_beats", en_cnt, 0);
        chk("bad_cfg_w_ready", w_ready, 0);

        start_layer(8, 4, 3);
        cyc = 0;
        while (en_cnt < 2 && cyc < 100) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        chk("reach_beat2", en_cnt, 2);
        rst = 1;
        @(negedge clk);
        rst = 0;
        #2;
        check_reset("mid_rst");
        repeat (10) @(negedge clk);
        #2;
        chk("mid_rst_no_done", done_cnt, 0);
        run_layer(6, 8, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
